// File: rtl/fp_pkg.sv
// Shared FPU definitions: rounding-mode codes, control-state encoding,
// width-generic special-value constructors and the common rounding decision.
package fp_pkg;

  // Rounding-mode encoding shared by the add/mul/div/sqrt units.
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RZ  = 3'b001,
    RM_RD  = 3'b010,
    RM_RU  = 3'b011,
    RM_RNA = 3'b100
  } rm_t;

  // Control states of the iterative units.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_NORM,
    ST_ITER,
    ST_ROUND,
    ST_FIN
  } state_t;

  // Widest operand the constructors below can build (covers FP128).
  localparam int FP_MAX_W = 128;

  // +infinity: sign 0, exponent all ones, fraction 0.
  function automatic logic [FP_MAX_W-1:0] fp_infp(input int ew, input int mw);
    logic [FP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < ew; i++) v[mw+i] = 1'b1;
    return v;
  endfunction

  // Canonical quiet NaN: +inf pattern with the fraction MSB set.
  function automatic logic [FP_MAX_W-1:0] fp_nanq(input int ew, input int mw);
    logic [FP_MAX_W-1:0] v;
    v = fp_infp(ew, mw);
    v[mw-1] = 1'b1;
    return v;
  endfunction

  // Round-increment decision from lsb/guard/sticky; unlisted codes truncate.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic guard,
                                     input logic sticky);
    logic inc;
    case (rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RNA:  inc = guard;
      RM_RU:   inc = ~sign & (guard | sticky);
      RM_RD:   inc = sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_sqrt_core.sv
// Restoring square-root datapath: consumes two radicand bits per step and
// produces one root bit per step. After MW+2 steps root holds the fraction
// and guard bits; sticky reports a non-zero final remainder.
module fp_sqrt_core #(
  parameter int MW = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [2*MW+3:0] radicand,
  output logic [MW:0]     root,
  output logic            sticky
);

  // Remainder never exceeds 2*root, plus two bits of headroom for the shift-in.
  localparam int RW = MW + 5;

  logic [2*MW+3:0] rad_q;
  logic [RW-1:0]   rem_q;
  logic [MW+1:0]   root_q;

  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   trial;
  logic            fits;

  // Trial subtraction for the next root bit.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rem_sh = {rem_q[RW-3:0], rad_q[2*MW+3:2*MW+2]};
    trial  = {1'b0, root_q, 2'b01};
    fits   = (rem_sh >= trial);
  end

  // Radicand/remainder/root registers: cleared on load, advanced on step.
  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: datapath registers are reset too, so an aborted operation leaves no stale root behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else if (load) begin
      rad_q  <= radicand;
      rem_q  <= '0;
      root_q <= '0;
    end else if (step) begin
      rad_q  <= rad_q << 2;
      rem_q  <= fits ? (rem_sh - trial) : rem_sh;
      root_q <= {root_q[MW:0], fits};
    end
  end

  // The integer root bit is always 1 for a normalised radicand and is not exported.
  assign root   = root_q[MW:0];
  assign sticky = |rem_q;

endmodule

// File: rtl/fp_sqrt_iter.sv
// Multi-cycle IEEE-754 square root with start/busy/done handshake.
// Owns the control FSM, operand unpack, special-value handling and rounding;
// the bit-serial root itself lives in fp_sqrt_core.
// Build option: define FP_SQRT_SUBNORM_EN to normalise subnormal operands
// (extra NORM cycles); otherwise subnormals are flushed to a same-signed zero.
module fp_sqrt_iter
  import fp_pkg::*;
#(
  parameter int EW   = 8,
  parameter int MW   = 23,
  parameter int BIAS = 2**(EW-1)-1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [EW+MW:0]  in1,
  input  logic [2:0]      round_m,
  output logic [EW+MW:0]  out,
  output logic            busy,
  output logic            done,
  output logic            ov,
  output logic            un,
  output logic            inv,
  output logic            inexact
);

  localparam int W  = EW + MW + 1;
  localparam int SW = $clog2(MW + 1);   // normalisation shift stages
  localparam int CW = $clog2(MW + 2);   // ITER step counter width

  typedef logic [EW+1:0] xexp_t;        // exponent with headroom for subnormal offsets
  typedef logic [SW:0]   amt_t;

  localparam logic [FP_MAX_W-1:0] QNAN_ALL = fp_nanq(EW, MW);
  localparam logic [FP_MAX_W-1:0] INFP_ALL = fp_infp(EW, MW);
  localparam logic [W-1:0]        QNAN     = QNAN_ALL[W-1:0];
  localparam logic [W-1:0]        INFP     = INFP_ALL[W-1:0];

`ifdef FP_SQRT_SUBNORM_EN
  localparam logic SUBNORM_EN = 1'b1;
`else
  localparam logic SUBNORM_EN = 1'b0;
`endif

  state_t          state;
  logic [W-1:0]    op_q;
  logic [2:0]      rm_q;
  logic [W-1:0]    res_q;
  logic            res_inv_q;
  logic            res_inx_q;
  logic [EW-1:0]   eres_q;
  logic [CW-1:0]   it_cnt;

  logic            op_sign;
  logic [EW-1:0]   op_exp;
  logic [MW-1:0]   op_frac;
  logic            exp_max;
  logic            exp_zero;
  logic            frac_zero;
  logic            unpack_normal;

  logic            core_load;
  logic            core_step;
  logic [2*MW+3:0] core_rad;
  logic [MW:0]     core_root;
  logic            core_sticky;

  logic [MW:0]     ld_sig;
  xexp_t           ld_exp;
  logic            ld_even;
  xexp_t           ld_sum;

  logic            rnd_inc;
  logic [MW:0]     frac_sum;

  assign op_sign   = op_q[W-1];
  assign op_exp    = op_q[W-2:MW];
  assign op_frac   = op_q[MW-1:0];
  assign exp_max   = &op_exp;
  assign exp_zero  = ~|op_exp;
  assign frac_zero = ~|op_frac;
  assign unpack_normal = ~exp_max & ~exp_zero & ~op_sign;

`ifdef FP_SQRT_SUBNORM_EN
  logic [MW:0] norm_sig;
  amt_t        norm_lz;
  amt_t        norm_amt;
  logic        norm_top_zero;
  logic [MW:0] norm_shifted;
  amt_t        norm_lz_next;
  logic        norm_last;

  // One logarithmic leading-zero stage per NORM cycle, widest shift first.
  always_comb begin
    norm_top_zero = ((norm_sig >> ((MW + 1) - int'(norm_amt))) == '0);
    norm_shifted  = norm_top_zero ? (norm_sig << norm_amt) : norm_sig;
    norm_lz_next  = norm_top_zero ? (norm_lz + norm_amt) : norm_lz;
    norm_last     = (norm_amt == amt_t'(1));
  end
`endif

  // Radicand and result exponent for the core load: odd E uses 1.f, even E uses 2x1.f.
  always_comb begin
    ld_sig = {1'b1, op_frac};
    ld_exp = xexp_t'(op_exp);
`ifdef FP_SQRT_SUBNORM_EN
    if (state == ST_NORM) begin
      ld_sig = norm_shifted;
      ld_exp = xexp_t'(1) - xexp_t'(norm_lz_next);
    end
`endif
    ld_even  = ~ld_exp[0];
    ld_sum   = ld_exp + xexp_t'(BIAS) - xexp_t'(ld_even);
    core_rad = ld_even ? {ld_sig, {(MW+3){1'b0}}} : {1'b0, ld_sig, {(MW+2){1'b0}}};
  end

  // Core control strobes.
  always_comb begin
    core_load = (state == ST_UNPACK) && unpack_normal;
`ifdef FP_SQRT_SUBNORM_EN
    if ((state == ST_NORM) && norm_last) core_load = 1'b1;
`endif
    core_step = (state == ST_ITER);
  end

  // Rounding of the MW-bit fraction; a carry out bumps the exponent.
  always_comb begin
    rnd_inc  = round_inc(rm_q, 1'b0, core_root[1], core_root[0], core_sticky);
    frac_sum = {1'b0, core_root[MW:1]} + {{MW{1'b0}}, rnd_inc};
  end

  fp_sqrt_core #(
    .MW(MW)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .radicand (core_rad),
    .root     (core_root),
    .sticky   (core_sticky)
  );

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      rm_q      <= '0;
      res_q     <= '0;
      res_inv_q <= 1'b0;
      res_inx_q <= 1'b0;
      eres_q    <= '0;
      it_cnt    <= '0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inv       <= 1'b0;
      inexact   <= 1'b0;
`ifdef FP_SQRT_SUBNORM_EN
      norm_sig  <= '0;
      norm_lz   <= '0;
      norm_amt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= in1;
            rm_q  <= round_m;
            busy  <= 1'b1;
            state <= ST_UNPACK;
          end
        end

        ST_UNPACK: begin
          res_inx_q <= 1'b0;
          res_inv_q <= 1'b0;
          if (exp_max) begin
            if (!frac_zero) begin
              res_q     <= QNAN;
              res_inv_q <= ~op_frac[MW-1];
            end else if (op_sign) begin
              res_q     <= QNAN;
              res_inv_q <= 1'b1;
            end else begin
              res_q     <= INFP;
            end
            state <= ST_FIN;
          end else if (exp_zero && (frac_zero || !SUBNORM_EN)) begin
            res_q <= {op_sign, {(W-1){1'b0}}};
            state <= ST_FIN;
          end else if (op_sign) begin
            res_q     <= QNAN;
            res_inv_q <= 1'b1;
            state     <= ST_FIN;
`ifdef FP_SQRT_SUBNORM_EN
          end else if (exp_zero) begin
            norm_sig <= {1'b0, op_frac};
            norm_lz  <= '0;
            norm_amt <= amt_t'(1) << (SW - 1);
            state    <= ST_NORM;
`endif
          end else begin
            eres_q <= EW'(ld_sum >> 1);
            it_cnt <= '0;
            state  <= ST_ITER;
          end
        end

`ifdef FP_SQRT_SUBNORM_EN
        ST_NORM: begin
          norm_sig <= norm_shifted;
          norm_lz  <= norm_lz_next;
          norm_amt <= norm_amt >> 1;
          if (norm_last) begin
            eres_q <= EW'(ld_sum >> 1);
            it_cnt <= '0;
            state  <= ST_ITER;
          end
        end
`endif

        ST_ITER: begin
          it_cnt <= it_cnt + 1'b1;
          if (it_cnt == CW'(MW + 1)) state <= ST_ROUND;
        end

        ST_ROUND: begin
          res_q     <= {1'b0, eres_q + EW'(frac_sum[MW]), frac_sum[MW-1:0]};
          res_inv_q <= 1'b0;
          res_inx_q <= core_root[0] | core_sticky;
          state     <= ST_FIN;
        end

        ST_FIN: begin
          out     <= res_q;
          inv     <= res_inv_q;
          inexact <= res_inx_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Square root can neither overflow nor underflow.
  assign ov = 1'b0;
  assign un = 1'b0;

endmodule

// File: tb/tb_fp_sqrt_iter.sv
// Self-checking bench for fp_sqrt_iter (FP32): directed cases plus random
// operands, checked by a scoreboard against a real/integer reference model.
module tb_fp_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in1 = '0;
  logic [2:0]  round_m = '0;
  logic [31:0] out;
  logic        busy, done, ov, un, inv, inexact;

  fp_sqrt_iter #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .round_m(round_m),
    .out(out), .busy(busy), .done(done), .ov(ov), .un(un), .inv(inv),
    .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_done = 0;
  logic done_prev = 1'b0;
  exp_t mon_e;

`ifdef FP_SQRT_SUBNORM_EN
  localparam bit SUBN = 1'b1;
`else
  localparam bit SUBN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: value-level square root with exact integer correction of $sqrt.
  task automatic model(input logic [31:0] x, input logic [2:0] rm, output exp_t e);
    logic       s;
    int         ex, ue;
    longint     sig, r, q, rem, trunc, mant;
    logic       guard, sticky, lsb, up;
    int         extra;
    s = x[31]; ex = int'(x[30:23]); sig = longint'(x[22:0]);
    e.x = x; e.inv = 1'b0; e.inx = 1'b0; e.lat = 2; extra = 0;
    if (ex == 255) begin
      if (sig != 0) begin e.res = 32'h7FC00000; e.inv = ~x[22]; end
      else if (s) begin e.res = 32'h7FC00000; e.inv = 1'b1; end
      else e.res = 32'h7F800000;
    end else if (ex == 0 && (sig == 0 || !SUBN)) begin
      e.res = {s, 31'd0};
    end else if (s) begin
      e.res = 32'h7FC00000; e.inv = 1'b1;
    end else begin
      if (ex == 0) begin
        ue = 1 - 127;
        while (sig < (64'd1 << 23)) begin sig = sig << 1; ue--; end
        extra = 5;
      end else begin
        sig = sig | (64'd1 << 23); ue = ex - 127;
      end
      if ((ue & 1) != 0) begin sig = sig * 2; ue = ue - 1; end
      // sqrt(sig/2^23) scaled by 2^24 == sqrt(sig * 2^25)
      r = sig << 25;
      q = longint'($sqrt(real'(r)));
      while (q * q > r) q--;
      while ((q + 1) * (q + 1) <= r) q++;
      rem = r - q * q;
      guard = q[0]; sticky = (rem != 0); trunc = q >> 1; lsb = trunc[0];
      case (rm)
        3'd0: up = guard && (sticky || lsb);   // nearest, ties to even
        3'd4: up = guard;                      // nearest, ties away
        3'd3: up = guard || sticky;            // toward +inf, positive result
        default: up = 1'b0;                    // RZ, RD and reserved codes truncate
      endcase
      mant = trunc + (up ? 64'd1 : 64'd0);
      ue = ue / 2 + 127;
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; ue++; end
      e.res = {1'b0, 8'(ue), mant[22:0]};
      e.inx = guard | sticky;
      e.lat = 28 + extra;
    end
  endtask

  // Wait for the unit to be idle, then present one request.
  task automatic issue(input logic [31:0] x, input logic [2:0] rm, input bit hold);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    check($sformatf("idle_wait_%h", x), 64'(busy), 64'd0);
    model(x, rm, e);
    e.acc = cyc + 1;
    sb.push_back(e);
    in1 = x; round_m = rm; start = 1'b1;
    @(negedge clk);
    if (hold) begin
      n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      check("hold_done_seen", 64'(done), 64'd1);
    end
    start = 1'b0;
  endtask

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      done_prev = 1'b0;
    end else begin
      if (done) begin
        n_done++;
        check("done_single_pulse", 64'(done_prev), 64'd0);
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got out=%h, want no done", out);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("out_%h_rm%0d", mon_e.x, round_m), 64'(out), 64'(mon_e.res));
          check($sformatf("inv_%h", mon_e.x), 64'(inv), 64'(mon_e.inv));
          check($sformatf("inexact_%h", mon_e.x), 64'(inexact), 64'(mon_e.inx));
          check($sformatf("ov_un_%h", mon_e.x), 64'({ov, un}), 64'd0);
          check($sformatf("latency_%h", mon_e.x), 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          check($sformatf("busy_at_done_%h", mon_e.x), 64'(busy), 64'd0);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] x;
    logic [2:0]  rm;
    int          n, d0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({out, busy, done, ov, un, inv, inexact}), 64'd0);
    rst = 1'b0;

    // Directed cases
    issue(32'h40800000, 3'd0, 1'b0);   // 4.0
    issue(32'h40000000, 3'd0, 1'b0);   // 2.0 RNe
    issue(32'h40000000, 3'd1, 1'b0);   // 2.0 RZ
    issue(32'h40000000, 3'd3, 1'b0);   // 2.0 RU
    issue(32'h40000000, 3'd2, 1'b0);   // 2.0 RD
    issue(32'h40000000, 3'd4, 1'b0);   // 2.0 RNa
    issue(32'h40000000, 3'd7, 1'b0);   // reserved code
    issue(32'hBF800000, 3'd0, 1'b0);   // -1.0
    issue(32'h7F800000, 3'd0, 1'b0);   // +inf
    issue(32'hFF800000, 3'd0, 1'b0);   // -inf
    issue(32'h80000000, 3'd0, 1'b0);   // -0
    issue(32'h00000000, 3'd0, 1'b0);   // +0
    issue(32'h7F800001, 3'd0, 1'b0);   // sNaN
    issue(32'h7FC12345, 3'd0, 1'b0);   // qNaN
    issue(32'h41100000, 3'd0, 1'b1);   // 9.0, start held while busy
    issue(32'h00000001, 3'd0, 1'b0);   // smallest subnormal
    issue(32'h80000001, 3'd0, 1'b0);   // negative subnormal
    issue(32'h7F7FFFFF, 3'd3, 1'b0);   // largest normal

    // Reset in the middle of ITER: no done, outputs cleared at once
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    in1 = 32'h40800000; round_m = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_abort", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'({out, busy, done, ov, un, inv, inexact}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    d0 = n_done;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(n_done - d0), 64'd0);
    check("abort_no_stale_out", 64'(out), 64'd0);
    issue(32'h40800000, 3'd0, 1'b0);

    // Random operands
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom())};
        6: x = {1'b0, 8'd0, 23'($urandom()) | 23'd1};
        7: x = {1'b1, 8'($urandom_range(0, 254)), 23'($urandom()) | 23'd1};
        default: begin
          case ($urandom_range(0, 5))
            0: x = 32'h7F800000;
            1: x = 32'hFF800000;
            2: x = {1'($urandom()), 8'hFF, 1'b0, 22'($urandom()) | 22'd1};
            3: x = {1'($urandom()), 8'hFF, 1'b1, 22'($urandom())};
            4: x = 32'h00000000;
            default: x = 32'h80000000;
          endcase
        end
      endcase
      rm = 3'($urandom_range(0, 7));
      issue(x, rm, 1'b0);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
